// File: rtl/i2s_transmitter_if.sv
// Sample handshake between a PCM source and the I2S transmitter.
// The transmitter takes a left/right pair when valid_in && ready_out.
interface i2s_transmitter_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic [SAMPLE_WIDTH-1:0] left_in;
  logic [SAMPLE_WIDTH-1:0] right_in;
  logic                    valid_in;
  logic                    ready_out;

  modport master (
    output left_in,
    output right_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  left_in,
    input  right_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: derives sclk/ws from clk_in and serialises stereo PCM MSB first.
// rst_in asserts asynchronously; its release is expected to be synchronous to clk_in.
module i2s_transmitter #(
  parameter int SCLK_DIV     = 16,
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  i2s_transmitter_if.slave     s_if,
  output logic                 sclk_out,
  output logic                 ws_out,
  output logic                 sdata_out,
  output logic                 frame_start_out,
  output logic [7:0]           underrun_count_out
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] BIT_RESET = CNT_W'(FRAME_BITS - 2);
  localparam logic [CNT_W-1:0] WS_RISE   = CNT_W'(SLOT_WIDTH - 1);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  buf_state_t r_buf_state;
  buf_state_t w_buf_state_next;

  logic [DIV_W-1:0]        r_div;
  logic                    r_sclk;
  logic                    r_ws;
  logic                    r_sdata;
  logic                    r_frame_start;
  logic                    r_ready;
  logic [7:0]              r_underrun;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [SAMPLE_WIDTH-1:0] r_buf_left;
  logic [SAMPLE_WIDTH-1:0] r_buf_right;
  logic [SAMPLE_WIDTH-1:0] r_last_left;
  logic [SAMPLE_WIDTH-1:0] r_last_right;

  logic                    w_tc;
  logic                    w_fe;
  logic                    w_load;
  logic                    w_accept;
  logic                    w_take_buf;
  logic [CNT_W-1:0]        w_bit_next;
  logic [FRAME_BITS-1:0]   w_frame_word;

  assign w_tc       = (r_div == DIV_LAST);
  assign w_fe       = w_tc && r_sclk;
  assign w_bit_next = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
  assign w_load     = w_fe && (w_bit_next == '0);
  assign w_accept   = s_if.valid_in && r_ready;

  // Buffer occupancy; the buffered pair is consumed only by a frame load.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_buf_state <= BUF_EMPTY;
      r_ready     <= 1'b1;
    end else begin
      r_buf_state <= w_buf_state_next;
      r_ready     <= (w_buf_state_next == BUF_EMPTY);
    end
  end

  always_comb begin
    w_buf_state_next = r_buf_state;
    w_take_buf       = 1'b0;
    case (r_buf_state)
      BUF_EMPTY: begin
        if (w_accept) begin
          w_buf_state_next = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (w_load) begin
          w_buf_state_next = BUF_EMPTY;
          w_take_buf       = 1'b1;
        end
      end
      default: begin
        w_buf_state_next = BUF_EMPTY;
      end
    endcase
  end

  // Frame layout: left sample at the top of slot 0, right at the top of slot 1, zero padded.
  always_comb begin
    w_frame_word = '0;
    if (w_take_buf) begin
      w_frame_word[FRAME_BITS-1 -: SAMPLE_WIDTH] = r_buf_left;
      w_frame_word[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = r_buf_right;
    end else begin
      w_frame_word[FRAME_BITS-1 -: SAMPLE_WIDTH] = r_last_left;
      w_frame_word[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = r_last_right;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_div         <= '0;
      r_sclk        <= 1'b0;
      r_ws          <= 1'b1;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 8'd0;
      r_bit_cnt     <= BIT_RESET;
      r_shift       <= '0;
      r_buf_left    <= '0;
      r_buf_right   <= '0;
      r_last_left   <= '0;
      r_last_right  <= '0;
    end else begin
      r_frame_start <= w_load;
      r_div         <= w_tc ? '0 : r_div + 1'b1;
      if (w_tc) begin
        r_sclk <= ~r_sclk;
      end

      if (w_fe) begin
        r_bit_cnt <= w_bit_next;
        // ws changes one bit ahead of the slot it announces.
        if (w_bit_next == BIT_LAST) begin
          r_ws <= 1'b0;
        end else if (w_bit_next == WS_RISE) begin
          r_ws <= 1'b1;
        end

        if (w_load) begin
          r_sdata <= w_frame_word[FRAME_BITS-1];
          r_shift <= {w_frame_word[FRAME_BITS-2:0], 1'b0};
          if (w_take_buf) begin
            r_last_left  <= r_buf_left;
            r_last_right <= r_buf_right;
          end else if (r_underrun != 8'hFF) begin
            r_underrun <= r_underrun + 8'd1;
          end
        end else begin
          r_sdata <= r_shift[FRAME_BITS-1];
          r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
        end
      end

      if (w_accept) begin
        r_buf_left  <= s_if.left_in;
        r_buf_right <= s_if.right_in;
      end
    end
  end

  assign s_if.ready_out       = r_ready;
  assign sclk_out             = r_sclk;
  assign ws_out               = r_ws;
  assign sdata_out            = r_sdata;
  assign frame_start_out      = r_frame_start;
  assign underrun_count_out   = r_underrun;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed + randomised bench for i2s_transmitter; every cycle's outputs are compared
// against a cycle-count based model of the I2S frame timing and the sample queue.
module tb_i2s_transmitter;

  localparam int D  = 2;
  localparam int W  = 24;
  localparam int S  = 32;
  localparam int FB = 2 * S;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk;
  logic       ws;
  logic       sdata;
  logic       fs;
  logic [7:0] urc;

  i2s_transmitter_if #(.SAMPLE_WIDTH(W)) bus ();

  i2s_transmitter #(
    .SCLK_DIV    (D),
    .SAMPLE_WIDTH(W),
    .SLOT_WIDTH  (S)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .s_if              (bus.slave),
    .sclk_out          (sclk),
    .ws_out            (ws),
    .sdata_out         (sdata),
    .frame_start_out   (fs),
    .underrun_count_out(urc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          c;
  bit          m_full;
  bit          m_acc;
  bit          m_load;
  logic [W-1:0] m_bl, m_br;
  logic [63:0] m_last;
  int          m_urc;
  logic [63:0] frames[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    return (64'(l) << (FB - W)) | (64'(r) << (S - W));
  endfunction

  // Frame loads happen on every 2*S-th sclk falling edge, starting with the second one.
  function automatic bit is_load(input int cc);
    int nfe;
    nfe = cc / (2 * D);
    return (cc % (2 * D) == 0) && (nfe >= 2) && ((nfe - 2) % FB == 0);
  endfunction

  task automatic model_reset();
    c      = 0;
    m_full = 1'b0;
    m_acc  = 1'b0;
    m_load = 1'b0;
    m_bl   = '0;
    m_br   = '0;
    m_last = '0;
    m_urc  = 0;
    frames.delete();
  endtask

  task automatic check_outputs();
    int          nfe;
    int          bc;
    int          k;
    logic [63:0] fw;
    logic        e_sclk, e_ws, e_sd;
    nfe    = c / (2 * D);
    bc     = (FB - 2 + nfe) % FB;
    e_sclk = ((c / D) % 2) != 0;
    e_ws   = (bc >= S - 1) && (bc <= FB - 2);
    e_sd   = 1'b0;
    if (nfe >= 2) begin
      k    = nfe - 2;
      fw   = frames[k / FB];
      e_sd = fw[FB - 1 - (k % FB)];
    end
    check("sclk", 64'(sclk), 64'(e_sclk));
    check("ws", 64'(ws), 64'(e_ws));
    check("sdata", 64'(sdata), 64'(e_sd));
    check("frame_start", 64'(fs), 64'(m_load));
    check("ready", 64'(bus.ready_out), 64'(!m_full));
    check("underrun", 64'(urc), 64'(m_urc));
  endtask

  task automatic tick();
    @(posedge clk);
    c++;
    m_acc  = bus.valid_in && !m_full;
    m_load = is_load(c);
    if (m_load) begin
      if (m_full) begin
        m_last = pack_frame(m_bl, m_br);
        m_full = 1'b0;
      end else if (m_urc < 255) begin
        m_urc++;
      end
      frames.push_back(m_last);
    end
    if (m_acc) begin
      m_bl   = bus.left_in;
      m_br   = bus.right_in;
      m_full = 1'b1;
    end
    #1;
    check_outputs();
  endtask

  task automatic run_frames(input int n);
    int target;
    target = frames.size() + n;
    while (frames.size() < target) tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sclk"}, 64'(sclk), 64'd0);
    check({tag, "_ws"}, 64'(ws), 64'd1);
    check({tag, "_sdata"}, 64'(sdata), 64'd0);
    check({tag, "_ready"}, 64'(bus.ready_out), 64'd1);
    check({tag, "_frame_start"}, 64'(fs), 64'd0);
    check({tag, "_underrun"}, 64'(urc), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    logic [W-1:0] base;

    model_reset();
    bus.valid_in = 1'b0;
    bus.left_in  = '0;
    bus.right_in = '0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Known pair before the first frame, then three frames without a sample.
    bus.left_in  = 24'hA5F00F;
    bus.right_in = 24'h800001;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("accept_ready_low", 64'(bus.ready_out), 64'd0);
    run_frames(1);
    check("first_frame_underrun", 64'(urc), 64'd0);
    run_frames(3);
    check("three_underruns", 64'(urc), 64'd3);

    // valid_in exactly on the frame-load cycle with an empty buffer.
    while (!is_load(c + 1)) tick();
    bus.left_in  = W'($urandom);
    bus.right_in = W'($urandom);
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("collision_underrun", 64'(urc), 64'd4);
    check("collision_ready", 64'(bus.ready_out), 64'd0);
    run_frames(1);
    check("collision_next_frame", 64'(urc), 64'd4);

    // valid_in held high with an incrementing sample stream.
    base         = W'($urandom);
    bus.left_in  = base;
    bus.right_in = ~base;
    bus.valid_in = 1'b1;
    f0 = frames.size();
    while (frames.size() < f0 + 6) begin
      tick();
      if (m_acc) begin
        bus.left_in  = bus.left_in + 1'b1;
        bus.right_in = ~bus.left_in;
      end
    end
    bus.valid_in = 1'b0;
    check("stream_no_underrun", 64'(urc), 64'd4);
    run_frames(1);

    // Long underrun run saturates the counter.
    run_frames(300);
    check("underrun_saturate", 64'(urc), 64'd255);

    // Buffer a pair, then reset asynchronously in the middle of the right slot.
    bus.left_in  = W'($urandom) | 24'h000001;
    bus.right_in = W'($urandom) | 24'h800000;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    while (((FB - 2 + c / (2 * D)) % FB) != S + 8) tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_frames(3);
    check("post_reset_underrun", 64'(urc), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Serialises stereo PCM samples onto a standard I2S link (sclk, ws, sdata) for an external DAC.
- It is the output-side counterpart to the I2S microphone receiver, used for the corrected-audio path in place of, or alongside, the PDM speaker output.
- Master mode: the block generates sclk and ws from clk_in and accepts samples through a one-entry valid/ready buffer.

Parameters:
- SCLK_DIV, 16, clk_in cycles per sclk half-period; must be >= 2. At 100 MHz this gives 3.125 MHz sclk and 48.8 kHz frames.
- SAMPLE_WIDTH, 24, bits per channel sample, MSB first; must be <= SLOT_WIDTH.
- SLOT_WIDTH, 32, sclk periods per channel slot; one frame is 2*SLOT_WIDTH bits.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- left_in  input  SAMPLE_WIDTH  left-channel sample, signed two's complement
- right_in  input  SAMPLE_WIDTH  right-channel sample
- valid_in  input  1  left_in and right_in are valid
- ready_out  output  1  holding buffer empty; the pair is accepted when valid_in && ready_out
- sclk_out  output  1  I2S bit clock
- ws_out  output  1  word select: 0 = left slot, 1 = right slot
- sdata_out  output  1  serial data
- frame_start_out  output  1  one-cycle pulse when a new frame is loaded into the shifter
- underrun_count_out  output  8  saturating count of frames with no fresh sample

Behaviour:
- Reset (async assert, deassert synchronised to clk_in), all outputs and state:
  - sclk_out=0, ws_out=1, sdata_out=0, ready_out=1, frame_start_out=0, underrun_count_out=0
  - divider=0, bit_cnt=2*SLOT_WIDTH-2, holding buffer empty
  - shifter=0, last-sample registers=0
- Reset mid-frame aborts the frame immediately with the values above. A pending buffered sample is discarded.
- Divider:
  - Counts 0..SCLK_DIV-1; on terminal count it wraps and toggles sclk_out.
  - A falling-edge event (fe) is the clk_in cycle in which sclk_out goes 1->0.
  - The first fe occurs 2*SCLK_DIV cycles after reset release.
- On each fe, bit_cnt increments modulo 2*SLOT_WIDTH; ws_out and sdata_out update in that same cycle.
- ws_out (standard I2S, ws leads data by one bit):
  - Registered 0 when the new bit_cnt = 2*SLOT_WIDTH-1.
  - Registered 1 when the new bit_cnt = SLOT_WIDTH-1.
  - Otherwise held.
- sdata_out:
  - For slot-local index b = bit_cnt mod SLOT_WIDTH: sample[SAMPLE_WIDTH-1-b] when b < SAMPLE_WIDTH, else 0.
  - Left sample in slot 0, right sample in slot 1.
  - Data changes only on fe; the DAC samples on the sclk rising edge.
- Frame load: on the fe where bit_cnt wraps to 0:
  - Buffer full: copy the buffer into the shifter and last-sample registers, then empty the buffer.
  - Buffer empty: reload the last-sample registers (repeat the previous frame) and increment underrun_count_out, saturating at 255.
  - frame_start_out pulses high for that one cycle in both cases. sdata_out in that cycle is the left MSB.
- Handshake:
  - ready_out = buffer empty, registered.
  - An accept captures left_in/right_in and drives ready_out to 0 from the next cycle.
  - ready_out returns to 1 the cycle after a frame load.
- Simultaneous valid_in and frame load with the buffer empty: the sample goes into the buffer for the next frame. The current frame repeats and counts an underrun; there is no bypass.
- Only one pair is accepted per frame. valid_in held high with ready_out low has no effect.
- Frame period is exactly 4*SLOT_WIDTH*SCLK_DIV clk_in cycles, independent of traffic.

Test Plan:
- Reset release, SCLK_DIV=2 -> sclk_out rises at cycle 2 and falls at cycle 4; ws_out goes 0 at cycle 4; frame_start_out pulses at cycle 8; sclk period is 4 cycles.
- Offer left=24'hA5F00F, right=24'h800001 before the first frame -> accepted in one cycle, ready_out=0. The bench decodes on sclk rising edges: left slot bits = A5F00F followed by 8 zeros, right slot = 800001 followed by 8 zeros. ws_out falls one bit before the left MSB and rises one bit before the right MSB.
- Provide no sample for 3 frames after a good frame -> the same data is retransmitted 3 times and underrun_count_out=3. Force 300 underruns -> the count saturates at 255.
- Assert valid_in in the exact cycle of frame_start_out with the buffer empty -> an underrun is counted for that frame; the new sample appears in the next frame; ready_out=0 until that frame's load.
- Hold valid_in high continuously with an incrementing sample -> exactly one accept per frame, no underruns, and the transmitted sequence matches the accepted sequence.
- Assert rst_in asynchronously mid right slot -> all outputs go to reset values without waiting for a clk_in edge. After release, timing matches the first scenario and the discarded buffered sample is never transmitted.
